// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ requesters.
// A granted word is registered onto tx_data, tx_send pulses once, then the
// arbiter follows tx_busy until the frame is over before granting again.
module uart_tx_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned DATA_W    = 9,
  parameter int unsigned BUSY_WAIT = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*DATA_W-1:0]    req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic [DATA_W-1:0]          tx_data,
  output logic                       tx_send,
  input  logic                       tx_busy,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       active,
  output logic                       tx_err
);

  localparam int unsigned GW = $clog2(N_REQ);
  localparam int unsigned CW = $clog2(BUSY_WAIT);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] SEND      = 2'd1;
  localparam logic [1:0] WAIT_RISE = 2'd2;
  localparam logic [1:0] WAIT_FALL = 2'd3;

  logic [1:0]        state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [GW-1:0]     last_grant, last_nxt;
  logic [GW-1:0]     grant_nxt;
  logic [DATA_W-1:0] tx_data_nxt;
  logic              tx_send_nxt, tx_err_nxt, active_nxt;

  logic [DATA_W-1:0] words [N_REQ];
  logic              sel_found;
  logic [GW-1:0]     sel_idx;
  logic [GW-1:0]     cand;
  logic [DATA_W-1:0] sel_data;

  // Unpack the flat request bus into per-requester words
  for (genvar g = 0; g < N_REQ; g++) begin : g_words
    assign words[g] = req_data[g*DATA_W +: DATA_W];
  end

  // Round-robin pick: first valid requester after last_grant, wrapping
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_data  = '0;
    cand      = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = GW'((32'(last_grant) + 32'd1 + k) % N_REQ);
      if (!sel_found && req_valid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
        sel_data  = words[cand];
      end
    end
  end

  // Accept handshake: only the picked requester, only when idle and line free
  always_comb begin
    req_ready = '0;
    if (reset && (state == IDLE) && !tx_busy && sel_found) begin
      req_ready[sel_idx] = 1'b1;
    end
  end

  // Next-state and registered-output values
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    last_nxt    = last_grant;
    grant_nxt   = grant_id;
    tx_data_nxt = tx_data;
    tx_send_nxt = 1'b0;
    tx_err_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (|req_ready) begin
          tx_data_nxt = sel_data;
          grant_nxt   = sel_idx;
          last_nxt    = sel_idx;
          tx_send_nxt = 1'b1;
          state_nxt   = SEND;
        end
      end
      SEND: begin
        cnt_nxt   = '0;
        state_nxt = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (tx_busy) begin
          state_nxt = WAIT_FALL;
        end else if (cnt == CW'(BUSY_WAIT - 2)) begin
          tx_err_nxt = 1'b1;
          state_nxt  = IDLE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      WAIT_FALL: begin
        if (!tx_busy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    active_nxt = (state_nxt != IDLE);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= GW'(N_REQ - 1);
      grant_id   <= '0;
      tx_data    <= '0;
      tx_send    <= 1'b0;
      tx_err     <= 1'b0;
      active     <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      last_grant <= last_nxt;
      grant_id   <= grant_nxt;
      tx_data    <= tx_data_nxt;
      tx_send    <= tx_send_nxt;
      tx_err     <= tx_err_nxt;
      active     <= active_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: cycle table, directed sequences, random traffic.
module tb_uart_tx_arbiter;

  localparam int unsigned N_REQ     = 4;
  localparam int unsigned DATA_W    = 9;
  localparam int unsigned BUSY_WAIT = 4;
  localparam int unsigned GW        = 2;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]       tx_data;
  logic                    tx_send;
  logic                    tx_busy;
  logic [GW-1:0]           grant_id;
  logic                    active;
  logic                    tx_err;

  uart_tx_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .BUSY_WAIT(BUSY_WAIT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_data(tx_data), .tx_send(tx_send), .tx_busy(tx_busy),
    .grant_id(grant_id), .active(active), .tx_err(tx_err)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: frame timeline in absolute cycle numbers
  bit                m_known   = 1'b0;
  bit                pending   = 1'b0;
  bit                seen_rise = 1'b0;
  int                t_acc     = -100;
  int                t_err     = -1;
  int                m_last    = N_REQ - 1;
  int                m_gid     = 0;
  logic [DATA_W-1:0] m_data    = '0;

  // Observation log
  int grant_q[$];
  int send_cnt = 0, err_cnt = 0, err_gap = 0, last_send_cyc = 0;

  // Transmitter stand-in
  bit use_stub = 1'b0, rand_stub = 1'b0, respond = 1'b1, busy_m = 1'b0;
  int rise_dly = 1, frame_len = 4, rise_cd = 0, hold_cd = 0;

  typedef struct {
    logic       rst;
    logic [3:0] valid;
    logic       busy;
    logic [3:0] ready;
    logic       send;
    logic       act;
    logic       err;
    logic [1:0] gid;
  } vec_t;

  localparam int NV = 27;
  vec_t tbl [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Round-robin choice computed by rotating a doubled valid vector
  function automatic int rr_pick(input int last, input logic [N_REQ-1:0] v);
    logic [2*N_REQ-1:0] dbl;
    int start;
    start = (last + 1) % N_REQ;
    dbl   = {v, v} >> start;
    for (int p = 0; p < N_REQ; p++) if (dbl[3'(p)]) return (start + p) % N_REQ;
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [N_REQ-1:0] v);
    for (int i = 0; i < N_REQ; i++) if (v[GW'(i)]) return i;
    return -1;
  endfunction

  // One clock: compare against model, advance model, then run the stand-in
  task automatic step();
    int pick;
    logic [N_REQ-1:0] exp_ready;
    pick = -1;
    exp_ready = '0;
    #1;
    if (m_known) begin
      if (reset && !pending && !tx_busy) begin
        pick = rr_pick(m_last, req_valid);
        if (pick >= 0) exp_ready[GW'(pick)] = 1'b1;
      end
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      chk("tx_send",   32'(tx_send),   32'(pending && (cyc == t_acc + 1)));
      chk("tx_err",    32'(tx_err),    32'(cyc == t_err));
      chk("active",    32'(active),    32'(pending));
      chk("grant_id",  32'(grant_id),  32'(m_gid));
      chk("tx_data",   32'(tx_data),   32'(m_data));
    end
    if (req_ready != '0) grant_q.push_back(onehot_idx(req_ready));
    if (tx_send) begin send_cnt++; last_send_cyc = cyc; end
    if (tx_err) begin err_cnt++; err_gap = cyc - last_send_cyc; end
    if (!reset) begin
      m_known = 1'b1; pending = 1'b0; seen_rise = 1'b0; t_acc = -100; t_err = -1;
      m_last = N_REQ - 1; m_gid = 0; m_data = '0;
    end else if (m_known) begin
      if (pick >= 0) begin
        pending = 1'b1; seen_rise = 1'b0; t_acc = cyc;
        m_last = pick; m_gid = pick; m_data = req_data[pick*DATA_W +: DATA_W];
      end else if (pending) begin
        if (seen_rise) begin
          if (!tx_busy) pending = 1'b0;
        end else if (cyc >= t_acc + 2) begin
          if (tx_busy) seen_rise = 1'b1;
          else if (cyc == t_acc + int'(BUSY_WAIT)) begin
            pending = 1'b0;
            t_err = cyc + 1;
          end
        end
      end
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
    if (use_stub) begin
      if (rise_cd > 0) begin
        rise_cd--;
        if (rise_cd == 0) begin busy_m = 1'b1; hold_cd = frame_len; end
      end else if (busy_m) begin
        hold_cd--;
        if (hold_cd == 0) busy_m = 1'b0;
      end
      if (tx_send) begin
        if (rand_stub) begin
          respond   = ($urandom_range(0, 9) != 0);
          rise_dly  = $urandom_range(0, 5);
          frame_len = $urandom_range(1, 12);
        end
        if (respond) begin
          if (rise_dly == 0) begin busy_m = 1'b1; hold_cd = frame_len; end
          else rise_cd = rise_dly;
        end
      end
      tx_busy = busy_m;
    end
  endtask

  initial begin
    //            rst   valid    busy  ready    send  act   err   gid
    tbl[0]  = '{1'b1, 4'b0001, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[1]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd0};
    tbl[2]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd0};
    tbl[3]  = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd0};
    tbl[4]  = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd0};
    tbl[5]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd0};
    tbl[6]  = '{1'b1, 4'b0010, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[7]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd1};
    tbl[8]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd1};
    tbl[9]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd1};
    tbl[10] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd1};
    tbl[11] = '{1'b1, 4'b1001, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b1, 2'd1};
    tbl[12] = '{1'b1, 4'b1001, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd3};
    tbl[13] = '{1'b1, 4'b1001, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd3};
    tbl[14] = '{1'b1, 4'b1001, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd3};
    tbl[15] = '{1'b1, 4'b1001, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd3};
    tbl[16] = '{1'b1, 4'b1001, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 2'd3};
    tbl[17] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd0};
    tbl[18] = '{1'b1, 4'b0010, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd0};
    tbl[19] = '{1'b0, 4'b0010, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd0};
    tbl[20] = '{1'b0, 4'b0010, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[21] = '{1'b1, 4'b0010, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[22] = '{1'b1, 4'b0010, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[23] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd1};
    tbl[24] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd1};
    tbl[25] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd1};
    tbl[26] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd1};

    reset = 1'b0; req_valid = '0; tx_busy = 1'b0;
    req_data = {9'h0C4, 9'h0B3, 9'h0A2, 9'h157};
    repeat (2) step();

    // Cycle table: single frame, sparse rotation, lost send, reset mid-frame
    for (int i = 0; i < NV; i++) begin
      reset = tbl[i].rst; req_valid = tbl[i].valid; tx_busy = tbl[i].busy;
      #1;
      chk($sformatf("tbl%0d_ready", i), 32'(req_ready), 32'(tbl[i].ready));
      chk($sformatf("tbl%0d_send", i),  32'(tx_send),   32'(tbl[i].send));
      chk($sformatf("tbl%0d_active", i), 32'(active),   32'(tbl[i].act));
      chk($sformatf("tbl%0d_err", i),   32'(tx_err),    32'(tbl[i].err));
      chk($sformatf("tbl%0d_gid", i),   32'(grant_id),  32'(tbl[i].gid));
      step();
    end

    // Single request with a long frame
    use_stub = 1'b1; respond = 1'b1; rise_dly = 3; frame_len = 220;
    busy_m = 1'b0; rise_cd = 0; tx_busy = 1'b0;
    grant_q.delete(); send_cnt = 0; err_cnt = 0;
    req_valid = 4'b0001;
    for (int c = 0; c < 10 && grant_q.size() == 0; c++) step();
    req_valid = '0;
    repeat (240) step();
    chk("single_grants", 32'(grant_q.size()), 32'd1);
    if (grant_q.size() > 0) chk("single_id", 32'(grant_q[0]), 32'd0);
    chk("single_sends", 32'(send_cnt), 32'd1);
    chk("single_errs", 32'(err_cnt), 32'd0);
    chk("single_data", 32'(tx_data), 32'h157);
    chk("single_idle", 32'(active), 32'd0);

    // Round robin with every requester valid
    reset = 1'b0; repeat (2) step(); reset = 1'b1;
    rise_dly = 1; frame_len = 4;
    grant_q.delete(); send_cnt = 0;
    req_data = {9'h104, 9'h103, 9'h102, 9'h101};
    req_valid = 4'b1111;
    for (int c = 0; c < 200 && grant_q.size() < 5; c++) step();
    req_valid = '0;
    repeat (20) step();
    chk("rr_count", 32'(grant_q.size() >= 5), 32'd1);
    for (int k = 0; k < 5; k++) if (k < grant_q.size()) chk($sformatf("rr_order%0d", k), 32'(grant_q[k]), 32'(k % 4));
    chk("rr_sends", 32'(send_cnt), 32'(grant_q.size()));

    // Transmitter never answers
    respond = 1'b0;
    grant_q.delete(); err_cnt = 0;
    req_valid = 4'b0101;
    repeat (12) step();
    req_valid = '0;
    repeat (10) step();
    chk("lost_err_cnt", 32'(err_cnt), 32'd3);
    chk("lost_err_gap", 32'(err_gap), 32'(BUSY_WAIT));
    chk("lost_grants", 32'(grant_q.size()), 32'd3);
    if (grant_q.size() >= 2) begin
      chk("lost_g0", 32'(grant_q[0]), 32'd2);
      chk("lost_g1", 32'(grant_q[1]), 32'd0);
    end

    // Busy already high coming out of reset
    use_stub = 1'b0; tx_busy = 1'b1;
    reset = 1'b0; repeat (2) step(); reset = 1'b1;
    grant_q.delete();
    req_valid = 4'b0001;
    repeat (5) step();
    chk("busy_start_hold", 32'(grant_q.size()), 32'd0);
    tx_busy = 1'b0;
    step();
    chk("busy_start_accept", 32'(grant_q.size()), 32'd1);
    req_valid = '0;
    repeat (8) step();

    // Random traffic with a randomised transmitter
    reset = 1'b0; step(); reset = 1'b1;
    use_stub = 1'b1; rand_stub = 1'b1; busy_m = 1'b0; rise_cd = 0; hold_cd = 0; tx_busy = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      req_valid = 4'($urandom & $urandom);
      req_data  = 36'({$urandom, $urandom});
      reset     = ($urandom_range(0, 299) != 0);
      step();
    end
    reset = 1'b1; req_valid = '0;
    repeat (40) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
